nanov_spi_ram_responder: RTL
============================

// Module: nanov_spi_ram_responder
// PURPOSE
//  SPI memory responder: the target end of the nanoV CPU's SPI fetch/load/store bus.
//  Decodes READ/WRITE commands from the CPU-side initiator and serves bytes from an internal RAM.
//  Runs on the CPU clock. spi_clk_enable marks the cycles that carry an SPI clock pulse.
//  Used in simulation benches and FPGA builds in place of external SPI RAM.
// PARAMETERS
//  ADDR_BITS   10   RAM holds 2**ADDR_BITS bytes. Received 24-bit address uses low ADDR_BITS bits only.
//  INIT_FILE   ""   If non-empty, $readmemh preload of RAM. Otherwise RAM is uninitialised.
// PORTS
//  clk             in   1  system clock; all sampling on rising edge
//  rst             in   1  asynchronous, active-high reset
//  spi_select      in   1  chip select, active-low; high = deselected
//  spi_in          in   1  host->responder serial data (MOSI), MSB first
//  spi_clk_enable  in   1  1 = SPI clock pulse this cycle; sample spi_in on this edge
//  spi_out         out  1  responder->host serial data (MISO), registered
//  busy            out  1  1 while state != IDLE
//  cmd_err         out  1  one-cycle pulse when an unsupported opcode completes
// BEHAVIOUR
//  - Reset (async): state=IDLE, bit counter=0, spi_out=0, busy=0, cmd_err=0. RAM contents untouched.
//  - A bit is "taken" on a clk edge with spi_select=0 && spi_clk_enable=1. No other edge changes state.
//  - spi_select=1 on any edge: state=IDLE, counter=0, spi_out=0. Any partial write byte is discarded.
//  - States: IDLE -> CMD -> ADDR -> {READ | WRITE}. CMD -> IGNORE on a bad opcode.
//  - IDLE: the first taken bit goes to CMD as bit 7 of the opcode.
//  - CMD: shift 8 bits MSB-first. On the 8th bit, decode:
//      0x03 -> ADDR (read); 0x02 -> ADDR (write); other -> IGNORE, and cmd_err pulses the next cycle.
//  - ADDR: shift 24 bits MSB-first into addr. The 32nd taken bit completes the address.
//  - READ: on the edge that takes the last address bit, load rdbyte=RAM[addr] and drive spi_out=rdbyte[7].
//      The bit is valid from the next cycle.
//  - READ, each later taken edge: shift out the next bit.
//      After bit 0 is shifted out, addr++, load RAM[addr], drive its bit 7 on the same edge. No gap between bytes.
//  - WRITE: every 8th taken bit after the address writes the assembled byte to RAM[addr], then addr++.
//  - Address increment wraps modulo 2**ADDR_BITS (0x3FF -> 0x000 at default).
//  - IGNORE: spi_out=0; stay until spi_select=1.
//  - spi_in is ignored while spi_out drives read data. spi_out=0 in all states except READ.
//  - Reset mid-transfer aborts immediately. The host must deselect before the next command.
//  - Read latency: first data bit valid 1 clk after the 32nd taken edge. Bits advance one per taken edge.
//  - Write-then-read of the same byte in separate transactions returns the written value.
// CONFIGURATION
//  FAST_READ_EN defined: also accept opcode 0x0B. After 24 address bits, take 8 dummy bits (state DUMMY).
//    RAM[addr] bit 7 is driven on the edge that takes the 8th dummy bit.
//    First data bit is valid 1 clk after the 40th taken edge.
//  FAST_READ_EN undefined: 0x0B is unsupported -> IGNORE + cmd_err pulse. No DUMMY state is built.
// TESTING
//  1 Reset: assert rst mid-READ -> spi_out=0, busy=0 same cycle. Next command after deselect decodes normally.
//  2 Write: sel=0, send 0x02,0x000010, bytes 0xA5,0x3C, sel=1
//      -> RAM[0x10]=0xA5, RAM[0x11]=0x3C. Nothing else changes.
//  3 Read: send 0x03,0x000010, clock 16 bits -> spi_out stream 0xA5 then 0x3C, MSB first, no gap.
//  4 Wrap: write 0x11 @0x3FF and 0x22 @0x000, then read 2 bytes from 0x3FF -> 0x11,0x22.
//      Address 0xFFF3FF aliases 0x3FF.
//  5 Abort/bad opcode: send 0x9F -> cmd_err one-cycle pulse, spi_out=0 until sel=1.
//      Write 0x02,0x000020 + 4 bits then sel=1 -> RAM[0x20] unchanged.
//  6 Gaps: spi_clk_enable low for 3 cycles between bits -> state and spi_out hold, data identical to test 3.
//      With FAST_READ_EN: 0x0B,0x000010 + 8 dummy -> 0xA5.

Source files
------------

// File: rtl/nanov_spi_ram_responder.sv
// SPI RAM target for the nanoV fetch/load/store bus: READ (0x03) / WRITE (0x02) into an internal byte RAM.
// Optional FAST_READ_EN adds opcode 0x0B with 8 dummy bits before data.
module nanov_spi_ram_responder #(
  parameter int    ADDR_BITS = 10,
  parameter string INIT_FILE = ""
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_select,
  input  logic spi_in,
  input  logic spi_clk_enable,
  output logic spi_out,
  output logic busy,
  output logic cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
    S_WRITE,
`ifdef FAST_READ_EN
    S_DUMMY,
`endif
    S_IGNORE
  } state_t;

  localparam logic [1:0] OP_RD = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
`ifdef FAST_READ_EN
  localparam logic [1:0] OP_FAST = 2'd2;
`endif

  state_t               state, state_nxt;
  logic [4:0]           cnt, cnt_nxt;
  logic [6:0]           sr, sr_nxt;
  logic [ADDR_BITS-1:0] addr, addr_nxt, addr_full, addr_inc;
  logic [6:0]           rdbyte, rdbyte_nxt;
  logic [1:0]           op, op_nxt;
  logic                 out_nxt, err_nxt;
  logic [7:0]           bit_byte;
  logic                 mem_we;
  logic [7:0]           mem [2**ADDR_BITS];

  assign bit_byte  = {sr, spi_in};
  assign addr_full = {addr[ADDR_BITS-2:0], spi_in};
  assign addr_inc  = addr + 1'b1;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sr_nxt     = sr;
    addr_nxt   = addr;
    rdbyte_nxt = rdbyte;
    op_nxt     = op;
    out_nxt    = spi_out;
    err_nxt    = 1'b0;
    mem_we     = 1'b0;
    if (spi_select) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 5'd0;
      out_nxt   = 1'b0;
    end else if (spi_clk_enable) begin
      case (state)
        S_IDLE: begin
          state_nxt = S_CMD;
          sr_nxt    = {6'd0, spi_in};
          cnt_nxt   = 5'd1;
        end
        S_CMD: begin
          sr_nxt  = bit_byte[6:0];
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt_nxt = 5'd0;
            case (bit_byte)
              8'h03: begin state_nxt = S_ADDR; op_nxt = OP_RD; end
              8'h02: begin state_nxt = S_ADDR; op_nxt = OP_WR; end
`ifdef FAST_READ_EN
              8'h0B: begin state_nxt = S_ADDR; op_nxt = OP_FAST; end
`endif
              default: begin state_nxt = S_IGNORE; err_nxt = 1'b1; end
            endcase
          end
        end
        S_ADDR: begin
          addr_nxt = addr_full;
          cnt_nxt  = cnt + 5'd1;
          if (cnt == 5'd23) begin
            cnt_nxt = 5'd0;
            case (op)
              OP_WR: state_nxt = S_WRITE;
`ifdef FAST_READ_EN
              OP_FAST: state_nxt = S_DUMMY;
`endif
              default: begin
                state_nxt  = S_READ;
                rdbyte_nxt = mem[addr_full][6:0];
                out_nxt    = mem[addr_full][7];
              end
            endcase
          end
        end
`ifdef FAST_READ_EN
        S_DUMMY: begin
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt_nxt    = 5'd0;
            state_nxt  = S_READ;
            rdbyte_nxt = mem[addr][6:0];
            out_nxt    = mem[addr][7];
          end
        end
`endif
        S_READ: begin
          // next byte's MSB follows bit 0 with no idle edge
          if (cnt == 5'd7) begin
            cnt_nxt    = 5'd0;
            addr_nxt   = addr_inc;
            rdbyte_nxt = mem[addr_inc][6:0];
            out_nxt    = mem[addr_inc][7];
          end else begin
            cnt_nxt    = cnt + 5'd1;
            rdbyte_nxt = {rdbyte[5:0], 1'b0};
            out_nxt    = rdbyte[6];
          end
        end
        S_WRITE: begin
          sr_nxt  = bit_byte[6:0];
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt_nxt  = 5'd0;
            mem_we   = 1'b1;
            addr_nxt = addr_inc;
          end
        end
        S_IGNORE: out_nxt = 1'b0;
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 5'd0;
          out_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 5'd0;
      sr      <= 7'd0;
      addr    <= '0;
      rdbyte  <= 7'd0;
      op      <= OP_RD;
      spi_out <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      sr      <= sr_nxt;
      addr    <= addr_nxt;
      rdbyte  <= rdbyte_nxt;
      op      <= op_nxt;
      spi_out <= out_nxt;
      cmd_err <= err_nxt;
    end
  end

  // RAM has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= bit_byte;
  end

endmodule
